// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC and issues in-order word requests to instruction memory.
// Returned words are queued with their PCs in a small FIFO that feeds decode.
// A redirect flushes the FIFO and restarts fetch at the new target. Responses
// to requests that were already in flight are counted and then discarded.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// redirect to a misaligned target raises a sticky o_misaligned flag and stops
// fetch. When it is not defined, the low target bits are forced to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [6:0]  o_opcode,
    output logic [31:0] o_pc,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        o_misaligned
`endif
);

    // DEPTH is restricted to 2 or 4, so the FIFO pointers wrap naturally.
    localparam int         PW      = (DEPTH > 2) ? 2 : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [31:0]   fpc;
    logic [31:0]   rpc;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    count;
    logic [3:0]    outs;
    logic [3:0]    drop;
    logic [3:0]    outs_next;
    logic [3:0]    credit_used;
    logic          started;
    logic [31:0]   last_inst;
    logic [31:0]   last_pc;
    logic          acc;
    logic          pop_raw;
    logic          pop;
    logic          push;
    logic          rsp_drop;
    logic          stall_mis;
    logic [31:0]   target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;

    assign stall_mis    = misaligned;
    assign o_misaligned = misaligned;

    // The misaligned flag is set or cleared by every redirect, depending on the target's low bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            misaligned <= 1'b0;
        end else if (i_redirect) begin
            misaligned <= |i_redirect_pc[1:0];
        end
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^i_redirect_pc[1:0];
    assign stall_mis       = 1'b0;
`endif

    assign target = {i_redirect_pc[31:2], 2'b00};

    // Request credit, handshakes and head-of-FIFO presentation.
    always_comb begin
        pop_raw          = (count != 4'd0) & i_inst_ready;
        credit_used      = outs + count - {3'b000, pop_raw};
        o_imem_req_valid = started & ~stall_mis & (credit_used < DEPTH_C);
        o_imem_addr      = fpc;
        acc              = o_imem_req_valid & i_imem_req_ready;
        pop              = pop_raw & ~i_redirect;
        push             = i_imem_rsp_valid & (drop == 4'd0) & ~i_redirect;
        rsp_drop         = i_imem_rsp_valid & (drop != 4'd0);
        outs_next        = outs + {3'b000, acc} - {3'b000, i_imem_rsp_valid};
        o_inst_valid     = (count != 4'd0);
        o_inst           = o_inst_valid ? fifo_inst[rd_ptr] : last_inst;
        o_pc             = o_inst_valid ? fifo_pc[rd_ptr]   : last_pc;
        o_opcode         = o_inst[6:0];
    end

    // FIFO storage; the count and pointers decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= i_imem_rsp_data;
            fifo_pc[wr_ptr]   <= rpc;
        end
    end

    // PCs, counters and pointers; a redirect overrides every other event in the cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            started   <= 1'b0;
            fpc       <= RESET_PC;
            rpc       <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 4'd0;
            outs      <= 4'd0;
            drop      <= 4'd0;
            last_inst <= 32'd0;
            last_pc   <= 32'd0;
        end else begin
            started   <= 1'b1;
            outs      <= outs_next;
            last_inst <= o_inst;
            last_pc   <= o_pc;
            if (i_redirect) begin
                fpc    <= target;
                rpc    <= target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= 4'd0;
                drop   <= outs_next;
            end else begin
                if (acc) begin
                    fpc <= fpc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rpc    <= rpc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (rsp_drop) begin
                    drop <= drop - 4'd1;
                end
                count <= count + {3'b000, push} - {3'b000, pop};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The memory is modelled as in-order queues with random latency. Every word's
// content is a fixed function of its address. The expected instruction stream
// is sequential from the last redirect target, or from the reset PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        w_valid;
    logic [31:0] w_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [31:0] w_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        w_mis;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat_max = 0;
    bit          mem_hold = 1'b0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fpc;
    bit          s_acc;
    bit          s_pop;
    logic        s_wvalid;
    logic [31:0] s_waddr;
    bit          prev_pend;
    bit          prev_redir;
    logic [31:0] prev_addr;
    int          pops;
    int          accs;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req_valid(req_valid), .o_imem_addr(addr), .i_imem_req_ready(req_ready),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .o_inst_valid(inst_valid), .o_inst(inst), .o_opcode(opcode), .o_pc(pc),
        .i_inst_ready(inst_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .o_misaligned(misaligned)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req_valid(w_valid), .o_imem_addr(w_addr), .i_imem_req_ready(1'b1),
        .i_imem_rsp_valid(1'b0), .i_imem_rsp_data(32'd0),
        .o_inst_valid(w_inst_valid), .o_inst(w_inst), .o_opcode(w_opcode), .o_pc(w_pc),
        .i_inst_ready(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'd0)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .o_misaligned(w_mis)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // One clock cycle. The caller has set the inputs at the falling edge. This
    // task drives the memory response, checks the outputs, updates the model,
    // and returns at the next falling edge.
    task automatic tick();
        logic [31:0] w;
        if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_at(mq_addr[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;
        s_acc    = req_valid && req_ready;
        s_pop    = inst_valid && inst_ready && !redirect;
        s_wvalid = w_valid;
        s_waddr  = w_addr;
        if (prev_redir) begin
            tests++;
            if (inst_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL post_redirect_valid: got %b want 0", inst_valid);
            end
        end
        if (prev_pend) begin
            tests++;
            if (req_valid !== 1'b1 || addr !== prev_addr) begin
                fails++;
                $display("[TB] FAIL req_hold: got valid=%b addr=%h want valid=1 addr=%h", req_valid, addr, prev_addr);
            end
        end
        if (s_acc) begin
            tests++;
            if (addr !== exp_fpc) begin
                fails++;
                $display("[TB] FAIL req_addr: got %h want %h", addr, exp_fpc);
            end
        end
        if (s_pop) begin
            w = word_at(exp_pc);
            tests++;
            if (pc !== exp_pc || inst !== w || opcode !== w[6:0]) begin
                fails++;
                $display("[TB] FAIL pop: got pc=%h inst=%h op=%h want pc=%h inst=%h op=%h", pc, inst, opcode, exp_pc, w, w[6:0]);
            end
        end
        if (rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_acc) begin
            mq_addr.push_back(addr);
            mq_due.push_back(cyc + 1 + int'($urandom_range(lat_max, 0)));
            exp_fpc += 32'd4;
        end
        if (s_pop) exp_pc += 32'd4;
        accs      += int'(s_acc);
        pops      += int'(s_pop);
        prev_pend  = req_valid && !req_ready && !redirect;
        prev_addr  = addr;
        prev_redir = redirect;
        if (redirect) begin
            exp_fpc = {redirect_pc[31:2], 2'b00};
            exp_pc  = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        redirect   = 1'b0;
        req_ready  = 1'b0;
        inst_ready = 1'b0;
        rsp_valid  = 1'b0;
        mem_hold   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        mq_addr.delete();
        mq_due.delete();
        exp_pc     = 32'd0;
        exp_fpc    = 32'd0;
        prev_pend  = 1'b0;
        prev_redir = 1'b0;
        pops       = 0;
        accs       = 0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        redirect   = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        rsp_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_valid !== 1'b0 || addr !== 32'd0 || inst_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_req: got valid=%b addr=%h ivalid=%b want 0/0/0", req_valid, addr, inst_valid);
        end
        tests++;
        if (inst !== 32'd0 || opcode !== 7'd0 || pc !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_head: got inst=%h op=%h pc=%h want 0", inst, opcode, pc);
        end
        tests++;
        if (w_valid !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
            fails++;
            $display("[TB] FAIL reset_wrap_pc: got valid=%b addr=%h want 0/fffffff8", w_valid, w_addr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++;
        if (misaligned !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mis: got %b want 0", misaligned);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_valid !== 1'b1 || addr !== 32'd0) begin
            fails++;
            $display("[TB] FAIL first_req: got valid=%b addr=%h want 1/0", req_valid, addr);
        end
    endtask

    task automatic test_stream();
        int first_acc;
        int first_pop;
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        lat_max    = 0;
        first_acc  = -1;
        first_pop  = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (s_acc && first_acc < 0) first_acc = i;
            if (s_pop && first_pop < 0) first_pop = i;
        end
        tests++;
        if (first_acc != 0 || first_pop != 2) begin
            fails++;
            $display("[TB] FAIL stream_latency: got acc@%0d pop@%0d want acc@0 pop@2", first_acc, first_pop);
        end
        tests++;
        if (accs != 14 || pops != 12) begin
            fails++;
            $display("[TB] FAIL stream_rate: got accs=%0d pops=%0d want 14/12", accs, pops);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b0;
        lat_max    = 0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (accs != 2 || req_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_credit: got accs=%0d valid=%b want 2/0", accs, req_valid);
        end
        inst_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (pops != 10 || exp_pc !== 32'd40) begin
            fails++;
            $display("[TB] FAIL bp_release: got pops=%0d next_pc=%h want 10/00000028", pops, exp_pc);
        end
    endtask

    task automatic test_redirect_late();
        int n;
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        lat_max    = 0;
        mem_hold   = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        accs = 0;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (accs != 0) begin
            fails++;
            $display("[TB] FAIL late_credit: got accs=%0d want 0", accs);
        end
        mem_hold = 1'b0;
        pops = 0;
        n = 0;
        while (pops < 3 && n < 30) begin
            tick();
            n++;
        end
        tests++;
        if (pops < 3 || exp_pc !== 32'h0000_010C) begin
            fails++;
            $display("[TB] FAIL late_restart: got pops=%0d next_pc=%h want 3/0000010c", pops, exp_pc);
        end
    endtask

    task automatic test_redirect_pop_rsp();
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        lat_max    = 0;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (inst_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL steady_valid: got %b want 1", inst_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0340;
        tick();
        tick();
        tests++;
        if (!s_acc || exp_fpc !== 32'h0000_0344) begin
            fails++;
            $display("[TB] FAIL redirect_restart: got acc=%b next_fpc=%h want 1/00000344", s_acc, exp_fpc);
        end
        pops = 0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (pops < 6) begin
            fails++;
            $display("[TB] FAIL redirect_flow: got pops=%0d want >=6", pops);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        lat_max    = 0;
        for (int i = 0; i < 3; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        tests++;
        if (misaligned !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mis_set: got %b want 1", misaligned);
        end
        accs = 0;
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if (accs != 0 || req_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mis_stall: got accs=%0d valid=%b want 0/0", accs, req_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        tests++;
        if (misaligned !== 1'b0 || req_valid !== 1'b1 || addr !== 32'h0000_0200) begin
            fails++;
            $display("[TB] FAIL mis_clear: got mis=%b valid=%b addr=%h want 0/1/00000200", misaligned, req_valid, addr);
        end
`endif
        pops = 0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (pops < 5) begin
            fails++;
            $display("[TB] FAIL mis_resume: got pops=%0d want >=5", pops);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [4];
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (i < 4) begin
                if (s_wvalid !== 1'b1 || s_waddr !== wexp[i]) begin
                    fails++;
                    $display("[TB] FAIL wrap_addr%0d: got valid=%b addr=%h want 1/%h", i, s_wvalid, s_waddr, wexp[i]);
                end
            end else if (s_wvalid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL wrap_credit: got valid=%b want 0", s_wvalid);
            end
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            req_ready  = ($urandom_range(3, 0) != 0);
            inst_ready = ($urandom_range(2, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
            tick();
        end
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        pops = 0;
        n = 0;
        while (pops < 20 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (pops < 20) begin
            fails++;
            $display("[TB] FAIL random_drain: got pops=%0d want >=20", pops);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = 32'd0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_late();
        test_redirect_pop_rsp();
        test_misalign();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
